// File: rtl/text_vmem.sv
// rtl/text_vmem.sv - scrolling text-mode video memory with keyboard writer and VGA read port
//
// Purpose:
//   Holds a COLS x ROWS screen of 8-bit character codes. A keyboard-driven
//   writer types printable characters, handles ENTER / BACKSPACE and scrolls
//   the screen by rotating a top-row pointer, so no data is ever moved. A
//   registered read port converts VGA pixel coordinates into the character
//   code, glyph pixel offsets and a cursor flag for a downstream glyph ROM.
//
// Ports:
//   clk        in   1    clock, all state changes on posedge
//   reset      in   1    synchronous, active-high
//   key_in     in   8    ASCII code from keyboard front end
//   key_valid  in   1    key_in valid this cycle
//   key_ready  out  1    block accepts a key this cycle (IDLE only)
//   h_addr     in   10   VGA pixel column
//   v_addr     in   10   VGA pixel row
//   ascii_out  out  8    character at the addressed cell (registered)
//   glyph_row  out  4    pixel row within the cell (registered)
//   glyph_col  out  4    pixel column within the cell (registered)
//   cursor_hit out  1    addressed cell is the cursor cell (registered)
//   cursor_x   out  XW   cursor column
//   cursor_y   out  YW   cursor logical row

module text_vmem #(
  parameter int COLS   = 70,
  parameter int ROWS   = 30,
  parameter int CHAR_W = 9,
  parameter int CHAR_H = 16,
  localparam int XW    = $clog2(COLS),
  localparam int YW    = $clog2(ROWS),
  localparam int AW    = $clog2(COLS * ROWS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    key_in,
  input  logic          key_valid,
  output logic          key_ready,
  input  logic [9:0]    h_addr,
  input  logic [9:0]    v_addr,
  output logic [7:0]    ascii_out,
  output logic [3:0]    glyph_row,
  output logic [3:0]    glyph_col,
  output logic          cursor_hit,
  output logic [XW-1:0] cursor_x,
  output logic [YW-1:0] cursor_y
);

  localparam int CELLS = COLS * ROWS;

  typedef enum logic [1:0] {
    CLR_ALL  = 2'd0,
    IDLE     = 2'd1,
    CLR_LINE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [7:0] mem [CELLS];

  // Writer state
  logic [AW-1:0] clr_addr;   // linear address during full-screen clear
  logic [YW-1:0] top_row;    // physical row shown as logical row 0
  logic [YW-1:0] clr_row;    // physical row being cleared after a scroll
  logic [XW-1:0] clr_col;    // column being cleared after a scroll

  // Single write port, driven by the output process
  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;

  // Logical row -> physical row. Both operands are below ROWS, so one
  // conditional subtract is enough; ROWS need not be a power of two.
  function automatic logic [YW-1:0] phys_row(input logic [YW-1:0] top,
                                             input logic [YW-1:0] row);
    logic [YW:0] sum;
    sum = {1'b0, top} + {1'b0, row};
    if (sum >= (YW+1)'(ROWS))
      sum = sum - (YW+1)'(ROWS);
    return YW'(sum);
  endfunction

  function automatic logic [AW-1:0] cell_addr(input logic [YW-1:0] prow,
                                              input logic [XW-1:0] col);
    return AW'(prow) * AW'(COLS) + AW'(col);
  endfunction

  // ------------------------------------------------------------------
  // Key decode
  // ------------------------------------------------------------------
  logic          accept;
  logic          is_print, is_enter, is_bs;
  logic          at_eol, at_last_row;
  logic          newline, scroll;
  logic          bs_ok;
  logic [XW-1:0] bs_x;
  logic [YW-1:0] bs_y;
  logic [AW-1:0] cur_addr, bs_addr;
  logic [YW-1:0] top_row_inc;

  assign accept      = key_valid & key_ready;
  assign is_print    = (key_in >= 8'h20) && (key_in <= 8'h7E);
  assign is_enter    = (key_in == 8'h0A);
  assign is_bs       = (key_in == 8'h08);
  assign at_eol      = (cursor_x == XW'(COLS - 1));
  assign at_last_row = (cursor_y == YW'(ROWS - 1));

  // A printable key in the last column wraps exactly like ENTER
  assign newline     = accept && (is_enter || (is_print && at_eol));
  assign scroll      = newline && at_last_row;

  // Backspace steps left, wrapping to the end of the previous line
  assign bs_ok       = (cursor_x != '0) || (cursor_y != '0);
  assign bs_x        = (cursor_x != '0) ? cursor_x - XW'(1) : XW'(COLS - 1);
  assign bs_y        = (cursor_x != '0) ? cursor_y : cursor_y - YW'(1);

  assign cur_addr    = cell_addr(phys_row(top_row, cursor_y), cursor_x);
  assign bs_addr     = cell_addr(phys_row(top_row, bs_y), bs_x);

  assign top_row_inc = (top_row == YW'(ROWS - 1)) ? '0 : top_row + YW'(1);

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset)
      state <= CLR_ALL;
    else
      state <= state_next;
  end

  // ------------------------------------------------------------------
  // FSM: next state
  // ------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      CLR_ALL:  if (clr_addr == AW'(CELLS - 1)) state_next = IDLE;
      IDLE:     if (scroll) state_next = CLR_LINE;
      CLR_LINE: if (clr_col == XW'(COLS - 1)) state_next = IDLE;
      default:  state_next = CLR_ALL;
    endcase
  end

  // ------------------------------------------------------------------
  // FSM: outputs (handshake and write port)
  // ------------------------------------------------------------------
  always_comb begin
    key_ready = 1'b0;
    we        = 1'b0;
    waddr     = '0;
    wdata     = 8'h00;
    // Reset dominates so no key is accepted and no stray write lands
    if (!reset) begin
      case (state)
        CLR_ALL: begin
          we    = 1'b1;
          waddr = clr_addr;
        end
        CLR_LINE: begin
          we    = 1'b1;
          waddr = cell_addr(clr_row, clr_col);
        end
        IDLE: begin
          key_ready = 1'b1;
          if (key_valid) begin
            if (is_print) begin
              we    = 1'b1;
              waddr = cur_addr;
              wdata = key_in;
            end else if (is_bs && bs_ok) begin
              we    = 1'b1;
              waddr = bs_addr;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Cursor, scroll pointer and clear counters
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_addr <= '0;
      cursor_x <= '0;
      cursor_y <= '0;
      top_row  <= '0;
      clr_row  <= '0;
      clr_col  <= '0;
    end else begin
      case (state)
        CLR_ALL:  clr_addr <= clr_addr + AW'(1);
        CLR_LINE: clr_col  <= clr_col + XW'(1);
        IDLE: begin
          if (newline) begin
            cursor_x <= '0;
            if (!at_last_row) begin
              cursor_y <= cursor_y + YW'(1);
            end else begin
              // The old top physical row becomes the new, blank bottom line
              top_row <= top_row_inc;
              clr_row <= top_row;
              clr_col <= '0;
            end
          end else if (accept && is_print) begin
            cursor_x <= cursor_x + XW'(1);
          end else if (accept && is_bs && bs_ok) begin
            cursor_x <= bs_x;
            cursor_y <= bs_y;
          end
        end
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Read path
  // ------------------------------------------------------------------
  logic [9:0]    cell_x_full, cell_y_full;
  logic          in_disp;
  logic [XW-1:0] cell_x;
  logic [YW-1:0] cell_y;
  logic [AW-1:0] raddr;

  assign cell_x_full = h_addr / 10'(CHAR_W);
  assign cell_y_full = v_addr / 10'(CHAR_H);
  // Comparing the cell index is equivalent to comparing the pixel against
  // COLS*CHAR_W / ROWS*CHAR_H
  assign in_disp     = (cell_x_full < 10'(COLS)) && (cell_y_full < 10'(ROWS));
  assign cell_x      = XW'(cell_x_full);
  assign cell_y      = YW'(cell_y_full);
  // Keep the array index in range when the beam is off-screen
  assign raddr       = in_disp ? cell_addr(phys_row(top_row, cell_y), cell_x) : '0;

  // Read and write share one block, so a same-cell access returns old data
  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    if (reset) begin
      ascii_out  <= 8'h00;
      glyph_row  <= 4'h0;
      glyph_col  <= 4'h0;
      cursor_hit <= 1'b0;
    end else begin
      ascii_out  <= in_disp ? mem[raddr] : 8'h00;
      glyph_row  <= 4'(v_addr % 10'(CHAR_H));
      glyph_col  <= 4'(h_addr % 10'(CHAR_W));
      cursor_hit <= in_disp && (cell_x == cursor_x) && (cell_y == cursor_y);
    end
  end

endmodule

// File: tb/tb_text_vmem.sv
// tb/tb_text_vmem.sv - directed self-checking bench for text_vmem

module tb_text_vmem;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] key_in;
  logic       key_valid;
  logic       key_ready;
  logic [9:0] h_addr;
  logic [9:0] v_addr;
  logic [7:0] ascii_out;
  logic [3:0] glyph_row;
  logic [3:0] glyph_col;
  logic       cursor_hit;
  logic [6:0] cursor_x;
  logic [4:0] cursor_y;

  int checks = 0;
  int errors = 0;

  text_vmem #(
    .COLS(70), .ROWS(30), .CHAR_W(9), .CHAR_H(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .h_addr     (h_addr),
    .v_addr     (v_addr),
    .ascii_out  (ascii_out),
    .glyph_row  (glyph_row),
    .glyph_col  (glyph_col),
    .cursor_hit (cursor_hit),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end on a negedge
  task automatic wait_ready(input string tag, input int exp);
    int n;
    n = 0;
    while (key_ready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    key_valid = 1'b0;
    chk(tag, n, exp);
  endtask

  task automatic send_key(input logic [7:0] k);
    int n;
    n = 0;
    while (key_ready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk("send_timeout", key_ready, 1);
    key_in    = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic read_px(input int h, input int v);
    h_addr = 10'(h);
    v_addr = 10'(v);
    @(negedge clk);
  endtask

  task automatic check_cell(input string tag, input int x, input int y, input logic [7:0] exp);
    read_px(x * 9, y * 16);
    chk(tag, ascii_out, exp);
  endtask

  task automatic check_cursor(input string tag, input int x, input int y);
    chk({tag, "_x"}, cursor_x, x);
    chk({tag, "_y"}, cursor_y, y);
  endtask

  initial begin
    reset     = 1'b1;
    key_in    = 8'h5A;
    key_valid = 1'b1;
    h_addr    = 10'd13;
    v_addr    = 10'd21;
    @(negedge clk);
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_key_ready", key_ready, 0);
    chk("rst_ascii", ascii_out, 0);
    chk("rst_glyph_row", glyph_row, 0);
    chk("rst_glyph_col", glyph_col, 0);
    chk("rst_cursor_hit", cursor_hit, 0);
    check_cursor("rst_cursor", 0, 0);

    // Full clear with a key held: 2100 cycles, key never consumed
    reset = 1'b0;
    wait_ready("clr_all_len", 2100);
    @(negedge clk);
    check_cursor("clr_all_cursor", 0, 0);
    for (int y = 0; y < 30; y++)
      for (int x = 0; x < 70; x++)
        check_cell("clr_all_cell", x, y, 8'h00);

    // 'A','B',ENTER,'C'
    send_key(8'h41);
    send_key(8'h42);
    send_key(8'h0A);
    send_key(8'h43);
    @(negedge clk);
    check_cursor("abc_cursor", 1, 1);
    check_cell("abc_00", 0, 0, 8'h41);
    check_cell("abc_10", 1, 0, 8'h42);
    check_cell("abc_01", 0, 1, 8'h43);
    check_cell("abc_20", 2, 0, 8'h00);
    read_px(9, 0);
    chk("rd_9_0_ascii", ascii_out, 8'h42);
    chk("rd_9_0_gcol", glyph_col, 0);
    chk("rd_9_0_grow", glyph_row, 0);
    read_px(13, 21);
    chk("rd_cur_ascii", ascii_out, 8'h00);
    chk("rd_cur_hit", cursor_hit, 1);
    chk("rd_cur_gcol", glyph_col, 4);
    chk("rd_cur_grow", glyph_row, 5);
    read_px(629, 31);
    chk("rd_edge_ascii", ascii_out, 8'h00);
    chk("rd_edge_gcol", glyph_col, 8);
    chk("rd_edge_grow", glyph_row, 15);
    chk("rd_edge_hit", cursor_hit, 0);
    read_px(630, 0);
    chk("rd_outh_ascii", ascii_out, 8'h00);
    read_px(0, 480);
    chk("rd_outv_ascii", ascii_out, 8'h00);
    chk("rd_outv_hit", cursor_hit, 0);

    // Reset mid-CLR_ALL restarts the clear from address 0
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_ready("clr_all_mid_rst", 2100);
    check_cell("clr2_00", 0, 0, 8'h00);
    check_cell("clr2_10", 1, 0, 8'h00);

    // 71 printable keys wrap to the next line
    for (int i = 0; i < 71; i++)
      send_key(8'(8'h21 + i));
    @(negedge clk);
    check_cursor("wrap_cursor", 1, 1);
    check_cell("wrap_00", 0, 0, 8'h21);
    check_cell("wrap_690", 69, 0, 8'h66);
    check_cell("wrap_01", 0, 1, 8'h67);

    // Backspace, including wrap to previous line and the (0,0) no-op
    send_key(8'h08);
    @(negedge clk);
    check_cursor("bs1_cursor", 0, 1);
    check_cell("bs1_01", 0, 1, 8'h00);
    send_key(8'h08);
    @(negedge clk);
    check_cursor("bs2_cursor", 69, 0);
    check_cell("bs2_690", 69, 0, 8'h00);
    check_cell("bs2_680", 68, 0, 8'h65);
    for (int i = 0; i < 69; i++)
      send_key(8'h08);
    @(negedge clk);
    check_cursor("bs3_cursor", 0, 0);
    check_cell("bs3_00", 0, 0, 8'h00);
    check_cell("bs3_350", 35, 0, 8'h00);
    send_key(8'h08);
    @(negedge clk);
    check_cursor("bs00_cursor", 0, 0);

    // Non-printable boundary codes are ignored, 0x7E is printable
    send_key(8'h7F);
    send_key(8'h1F);
    @(negedge clk);
    check_cursor("ign_cursor", 0, 0);
    check_cell("ign_00", 0, 0, 8'h00);
    send_key(8'h7E);
    @(negedge clk);
    check_cursor("tilde_cursor", 1, 0);
    check_cell("tilde_00", 0, 0, 8'h7E);

    // Scroll: mark rows 1 and 29, then ENTER on the last row
    send_key(8'h0A);
    send_key(8'h51);
    for (int i = 0; i < 28; i++)
      send_key(8'h0A);
    @(negedge clk);
    check_cursor("pre_scroll_cursor", 0, 29);
    send_key(8'h52);
    key_in    = 8'h0A;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    wait_ready("scroll_len", 70);
    check_cursor("scroll_cursor", 0, 29);
    check_cell("scroll_row0", 0, 0, 8'h51);
    check_cell("scroll_row28", 0, 28, 8'h52);
    check_cell("scroll_row28_1", 1, 28, 8'h00);
    for (int x = 0; x < 70; x++)
      check_cell("scroll_row29", x, 29, 8'h00);

    // Reset during CLR_LINE
    send_key(8'h0A);
    repeat (10) @(negedge clk);
    chk("clr_line_busy", key_ready, 0);
    reset     = 1'b1;
    key_in    = 8'h5A;
    key_valid = 1'b1;
    @(negedge clk);
    chk("line_rst_ready", key_ready, 0);
    check_cursor("line_rst_cursor", 0, 0);
    reset = 1'b0;
    wait_ready("clr_all_after_line", 2100);
    @(negedge clk);
    check_cursor("line_rst_cursor2", 0, 0);
    check_cell("line_rst_00", 0, 0, 8'h00);
    check_cell("line_rst_6929", 69, 29, 8'h00);
    send_key(8'h5A);
    @(negedge clk);
    check_cell("line_rst_z", 0, 0, 8'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
